// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access stage.
// The state enum is used by mem_access_ctrl; sizes bound the wait counter.
package lc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

  localparam int WORD_W   = 16;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/mem_access_ctrl.sv
// MAR/MDR holding stage with a fixed-wait-state SRAM read/write handshake.
// Strobes, Busy and R are decoded purely from the state and op registers.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] Bus_In,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              Mem_Req,
  input  logic              Mem_Wr,
  input  logic [WORD_W-1:0] Data_from_SRAM,
  output logic [ADDR_W-1:0] MAR,
  output logic [WORD_W-1:0] MDR,
  output logic [WORD_W-1:0] Data_to_SRAM,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              Busy,
  output logic              R
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       state;
  mem_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_wr;
  logic             read_capture;

  assign read_capture = (state == ACCESS) && !op_wr && (cnt == LAST_CNT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Mem_Req) state_nxt = ACCESS;
      ACCESS:  if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation type and wait counter are latched when a request is accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      op_wr <= 1'b0;
    end else if (state == IDLE) begin
      if (Mem_Req) begin
        cnt   <= '0;
        op_wr <= Mem_Wr;
      end
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MAR <= '0;
    end else if (!Busy && LD_MAR) begin
      MAR <= Bus_In[ADDR_W-1:0];
    end
  end

  // Bus loads are locked out while busy, so read capture never competes with LD_MDR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MDR <= '0;
    end else if (read_capture) begin
      MDR <= Data_from_SRAM;
    end else if (!Busy && LD_MDR) begin
      MDR <= Bus_In;
    end
  end

  always_comb begin
    CE_N = 1'b1;
    OE_N = 1'b1;
    WE_N = 1'b1;
    if (state == ACCESS) begin
      CE_N = 1'b0;
      OE_N = op_wr;
      WE_N = !op_wr;
    end
  end

  assign Busy         = (state != IDLE);
  assign R            = (state == DONE);
  assign Data_to_SRAM = MDR;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl against a
// transaction-level model that tracks remaining busy cycles per access.
module tb_mem_access_ctrl;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Bus_In = '0;
  logic        LD_MAR = 1'b0;
  logic        LD_MDR = 1'b0;
  logic        Mem_Req = 1'b0;
  logic        Mem_Wr = 1'b0;
  logic [15:0] Data_from_SRAM = '0;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Data_to_SRAM;
  logic        CE_N, OE_N, WE_N, Busy, R;

  mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Bus_In(Bus_In), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Data_from_SRAM(Data_from_SRAM),
    .MAR(MAR), .MDR(MDR), .Data_to_SRAM(Data_to_SRAM),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .Busy(Busy), .R(R)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: left = cycles of busyness remaining (W access cycles + 1 done cycle).
  int          m_left = 0;
  logic        m_wr   = 1'b0;
  logic [15:0] m_mar  = '0;
  logic [15:0] m_mdr  = '0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_wr   = 1'b0;
    m_mar  = '0;
    m_mdr  = '0;
  endtask

  task automatic check_all();
    chk_eq("mar",  32'(MAR), 32'(m_mar));
    chk_eq("mdr",  32'(MDR), 32'(m_mdr));
    chk_eq("dout", 32'(Data_to_SRAM), 32'(m_mdr));
    chk_eq("ce_n", 32'(CE_N), 32'(!(m_left > 1)));
    chk_eq("oe_n", 32'(OE_N), 32'(!(m_left > 1 && !m_wr)));
    chk_eq("we_n", 32'(WE_N), 32'(!(m_left > 1 && m_wr)));
    chk_eq("busy", 32'(Busy), 32'(m_left > 0));
    chk_eq("r",    32'(R),    32'(m_left == 1));
  endtask

  task automatic step();
    @(posedge Clk);
    if (Reset) begin
      model_reset();
    end else begin
      if (m_left == 0 && LD_MAR) m_mar = Bus_In;
      if (m_left == 2 && !m_wr) m_mdr = Data_from_SRAM;
      else if (m_left == 0 && LD_MDR) m_mdr = Bus_In;
      if (m_left == 0) begin
        if (Mem_Req) begin
          m_left = W + 1;
          m_wr   = Mem_Wr;
        end
      end else begin
        m_left--;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic lm, input logic ld, input logic rq, input logic wr,
                       input logic [15:0] bus, input logic [15:0] sd);
    LD_MAR = lm; LD_MDR = ld; Mem_Req = rq; Mem_Wr = wr;
    Bus_In = bus; Data_from_SRAM = sd;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_cnt, last_r, we_cnt;

    // Power-up reset
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    #2 Reset = 1'b0;
    idle(2);

    // 1. Reset asserted asynchronously during the first ACCESS cycle
    drive(1, 0, 0, 0, 16'h0077, 16'h0);
    step();
    drive(0, 0, 1, 0, 16'h0, 16'h9999);
    step();
    chk_eq("rst_pre_ce", 32'(CE_N), 32'(0));
    drive(0, 0, 0, 0, 16'h0, 16'h9999);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    chk_eq("rst_ce", 32'(CE_N), 32'(1));
    chk_eq("rst_oe", 32'(OE_N), 32'(1));
    chk_eq("rst_we", 32'(WE_N), 32'(1));
    chk_eq("rst_mar", 32'(MAR), 32'(0));
    chk_eq("rst_mdr", 32'(MDR), 32'(0));
    chk_eq("rst_busy", 32'(Busy), 32'(0));
    step();
    #1 Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("rst_no_r", 32'(R), 32'(0));
    end

    // 2. Basic read
    drive(1, 0, 0, 0, 16'h3000, 16'h0);
    step();
    drive(0, 0, 1, 0, 16'h0, 16'hBEEF);
    step();
    chk_eq("rd_oe1", 32'(OE_N), 32'(0));
    drive(0, 0, 0, 0, 16'h0, 16'hBEEF);
    step();
    chk_eq("rd_oe2", 32'(OE_N), 32'(0));
    step();
    chk_eq("rd_mdr", 32'(MDR), 32'(16'hBEEF));
    chk_eq("rd_r", 32'(R), 32'(1));
    chk_eq("rd_mar", 32'(MAR), 32'(16'h3000));
    step();
    chk_eq("rd_r_off", 32'(R), 32'(0));
    idle(1);

    // 3. Basic write
    drive(1, 0, 0, 0, 16'h0042, 16'h0);
    step();
    drive(0, 1, 0, 0, 16'h1234, 16'h0);
    step();
    drive(0, 0, 1, 1, 16'h0, 16'h5A5A);
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      drive(0, 0, 0, 0, 16'h0, 16'h5A5A);
      if (WE_N == 1'b0) we_cnt++;
      chk_eq("wr_dout", 32'(Data_to_SRAM), 32'(16'h1234));
    end
    chk_eq("wr_we_cycles", 32'(we_cnt), 32'(W));
    chk_eq("wr_mar", 32'(MAR), 32'(16'h0042));
    idle(1);

    // 4. Loads blocked while busy
    drive(1, 0, 0, 0, 16'h0010, 16'h0);
    step();
    drive(0, 0, 1, 0, 16'h0, 16'hC0DE);
    step();
    drive(1, 0, 0, 0, 16'hFFFF, 16'hC0DE);
    step();
    drive(0, 1, 0, 0, 16'hAAAA, 16'hC0DE);
    step();
    chk_eq("blk_mar", 32'(MAR), 32'(16'h0010));
    chk_eq("blk_mdr", 32'(MDR), 32'(16'hC0DE));
    idle(2);

    // 5. Held request
    drive(0, 0, 1, 0, 16'h0, 16'h1111);
    r_cnt = 0;
    last_r = -100;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (R) begin
        if (r_cnt > 0) chk_eq("held_gap", 32'(i - last_r), 32'(W + 2));
        r_cnt++;
        last_r = i;
      end
    end
    chk_eq("held_count", 32'(r_cnt), 32'(4));
    idle(4);

    // 6. Same-edge load and request
    drive(1, 0, 1, 0, 16'h5555, 16'h2222);
    step();
    chk_eq("same_mar", 32'(MAR), 32'(16'h5555));
    chk_eq("same_ce", 32'(CE_N), 32'(0));
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
            1'($urandom), 16'($urandom), 16'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
